// File: rtl/axi4_stream_frag_trailer.sv
// Registers each fragment beat through one output stage with tlast cleared, then appends a
// trailer beat (byte count, sequence number, word count, magic, overflow flag) that carries tlast.
module axi4_stream_frag_trailer #(
  parameter int unsigned TDATA_WIDTH   = 64,
  parameter int unsigned TID_WIDTH     = 1,
  parameter int unsigned TDEST_WIDTH   = 1,
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned MAX_FRAG_SIZE = 2048,
  parameter logic [7:0]  TRAILER_MAGIC = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     pkt_i_tvalid,
  output logic                     pkt_i_tready,
  input  logic [TDATA_WIDTH-1:0]   pkt_i_tdata,
  input  logic [TDATA_WIDTH/8-1:0] pkt_i_tkeep,
  input  logic [TDATA_WIDTH/8-1:0] pkt_i_tstrb,
  input  logic [TID_WIDTH-1:0]     pkt_i_tid,
  input  logic [TDEST_WIDTH-1:0]   pkt_i_tdest,
  input  logic [TUSER_WIDTH-1:0]   pkt_i_tuser,
  input  logic                     pkt_i_tlast,
  output logic                     pkt_o_tvalid,
  input  logic                     pkt_o_tready,
  output logic [TDATA_WIDTH-1:0]   pkt_o_tdata,
  output logic [TDATA_WIDTH/8-1:0] pkt_o_tkeep,
  output logic [TDATA_WIDTH/8-1:0] pkt_o_tstrb,
  output logic [TID_WIDTH-1:0]     pkt_o_tid,
  output logic [TDEST_WIDTH-1:0]   pkt_o_tdest,
  output logic [TUSER_WIDTH-1:0]   pkt_o_tuser,
  output logic                     pkt_o_tlast,
  output logic                     dbg_state
);

  // Handshakes: a beat transfers on a rising clk_i edge where tvalid && tready; once tvalid is
  // raised the source keeps it and all payload stable until that transfer.

  localparam int unsigned KEEP_W = TDATA_WIDTH / 8;
  localparam int unsigned POP_W  = $clog2(KEEP_W) + 1;
  localparam int unsigned CNT_W  = $clog2(MAX_FRAG_SIZE) + 1;
  localparam logic [CNT_W:0] MAX_SUM = (CNT_W+1)'(MAX_FRAG_SIZE);

  typedef enum logic {PASS = 1'b0, TRAILER = 1'b1} state_t;

  state_t                 state, state_nx;
  logic                   out_valid, out_last;
  logic                   in_hs, out_hs, load_trl, trl_hs;
  logic [CNT_W-1:0]       byte_cnt;
  logic [CNT_W:0]         byte_sum;
  logic [POP_W-1:0]       keep_pop;
  logic [15:0]            word_cnt, frag_seq;
  logic                   ovf;
  logic [TID_WIDTH-1:0]   lat_id;
  logic [TDEST_WIDTH-1:0] lat_dest;
  logic [TUSER_WIDTH-1:0] lat_user;
  logic [TDATA_WIDTH-1:0] trailer_data;

  assign in_hs    = pkt_i_tvalid && pkt_i_tready;
  assign out_hs   = out_valid && pkt_o_tready;
  // In TRAILER the register holds the last data beat until it leaves, then the trailer.
  assign load_trl = (state == TRAILER) && out_hs && !out_last;
  assign trl_hs   = (state == TRAILER) && out_hs && out_last;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= PASS;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      PASS:    if (in_hs && pkt_i_tlast) state_nx = TRAILER;
      TRAILER: if (trl_hs)               state_nx = PASS;
      default: state_nx = PASS;
    endcase
  end

  always_comb begin
    pkt_i_tready = (state == PASS) && (!out_valid || pkt_o_tready);
    dbg_state    = state;
  end

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < KEEP_W; i++) keep_pop = keep_pop + POP_W'(pkt_i_tkeep[i]);
    byte_sum = {1'b0, byte_cnt} + (CNT_W+1)'(keep_pop);
  end

  always_comb begin
    trailer_data        = '0;
    trailer_data[15:0]  = 16'(byte_cnt);
    trailer_data[31:16] = frag_seq;
    trailer_data[47:32] = word_cnt;
    trailer_data[55:48] = TRAILER_MAGIC;
    trailer_data[63]    = ovf;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      frag_seq <= '0;
      ovf      <= 1'b0;
      lat_id   <= '0;
      lat_dest <= '0;
      lat_user <= '0;
    end else if (in_hs) begin
      // Oversized fragments still pass; the count pins at the limit and ovf flags it.
      if (byte_sum > MAX_SUM) begin
        byte_cnt <= CNT_W'(MAX_FRAG_SIZE);
        ovf      <= 1'b1;
      end else begin
        byte_cnt <= byte_sum[CNT_W-1:0];
      end
      if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
      if (byte_cnt == '0 && word_cnt == '0) begin
        lat_id   <= pkt_i_tid;
        lat_dest <= pkt_i_tdest;
        lat_user <= pkt_i_tuser;
      end
    end else if (trl_hs) begin
      byte_cnt <= '0;
      word_cnt <= '0;
      ovf      <= 1'b0;
      frag_seq <= frag_seq + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      pkt_o_tdata <= '0;
      pkt_o_tkeep <= '0;
      pkt_o_tstrb <= '0;
      pkt_o_tid   <= '0;
      pkt_o_tdest <= '0;
      pkt_o_tuser <= '0;
    end else if (in_hs) begin
      out_valid   <= 1'b1;
      out_last    <= 1'b0;
      pkt_o_tdata <= pkt_i_tdata;
      pkt_o_tkeep <= pkt_i_tkeep;
      pkt_o_tstrb <= pkt_i_tstrb;
      pkt_o_tid   <= pkt_i_tid;
      pkt_o_tdest <= pkt_i_tdest;
      pkt_o_tuser <= pkt_i_tuser;
    end else if (load_trl) begin
      out_last    <= 1'b1;
      pkt_o_tdata <= trailer_data;
      pkt_o_tkeep <= '1;
      pkt_o_tstrb <= '1;
      pkt_o_tid   <= lat_id;
      pkt_o_tdest <= lat_dest;
      pkt_o_tuser <= lat_user;
    end else if (out_hs) begin
      out_valid   <= 1'b0;
    end
  end

  assign pkt_o_tvalid = out_valid;
  assign pkt_o_tlast  = out_last;

endmodule

// File: tb/tb_axi4_stream_frag_trailer.sv
// Directed bench: drives fragments, scoreboards every output beat against hand-computed
// data beats and trailer words, and checks reset, stall stability and inter-fragment bubbles.
module tb_axi4_stream_frag_trailer;

  logic        clk, rst_n;
  logic        pkt_i_tvalid, pkt_i_tready, pkt_i_tlast;
  logic [63:0] pkt_i_tdata;
  logic [7:0]  pkt_i_tkeep, pkt_i_tstrb;
  logic        pkt_i_tid, pkt_i_tdest, pkt_i_tuser;
  logic        pkt_o_tvalid, pkt_o_tready, pkt_o_tlast;
  logic [63:0] pkt_o_tdata;
  logic [7:0]  pkt_o_tkeep, pkt_o_tstrb;
  logic        pkt_o_tid, pkt_o_tdest, pkt_o_tuser;
  logic        dbg_state;

  logic [127:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           last_stall;
  logic         mon_en   = 1'b0;
  logic         rnd_en   = 1'b0;

  axi4_stream_frag_trailer dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .pkt_i_tvalid(pkt_i_tvalid), .pkt_i_tready(pkt_i_tready), .pkt_i_tdata(pkt_i_tdata),
    .pkt_i_tkeep(pkt_i_tkeep), .pkt_i_tstrb(pkt_i_tstrb), .pkt_i_tid(pkt_i_tid),
    .pkt_i_tdest(pkt_i_tdest), .pkt_i_tuser(pkt_i_tuser), .pkt_i_tlast(pkt_i_tlast),
    .pkt_o_tvalid(pkt_o_tvalid), .pkt_o_tready(pkt_o_tready), .pkt_o_tdata(pkt_o_tdata),
    .pkt_o_tkeep(pkt_o_tkeep), .pkt_o_tstrb(pkt_o_tstrb), .pkt_o_tid(pkt_o_tid),
    .pkt_o_tdest(pkt_o_tdest), .pkt_o_tuser(pkt_o_tuser), .pkt_o_tlast(pkt_o_tlast),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic l, input logic [2:0] idu,
                                        input logic [7:0] k, input logic [7:0] s,
                                        input logic [63:0] d);
    return {44'd0, l, idu, s, k, d};
  endfunction

  // sink ready: always 1, or a coin flip per cycle while rnd_en is set
  initial begin
    pkt_o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      pkt_o_tready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor / scoreboard
  initial begin
    logic         stalled;
    logic [127:0] held, obs;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      obs = pack(pkt_o_tlast, {pkt_o_tid, pkt_o_tdest, pkt_o_tuser}, pkt_o_tkeep, pkt_o_tstrb,
                 pkt_o_tdata);
      if (!mon_en) begin
        stalled = 1'b0;
      end else begin
        if (stalled) check("stall_stable", {pkt_o_tvalid, obs}, {1'b1, held});
        stalled = pkt_o_tvalid && !pkt_o_tready;
        held    = obs;
        if (pkt_o_tvalid && pkt_o_tready) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("beat", obs, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks; callers are at posedge+1
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic [2:0] idu,
                           input logic l);
    int   waits;
    logic acc;
    pkt_i_tvalid = 1'b1;
    pkt_i_tdata  = d;
    pkt_i_tkeep  = k;
    pkt_i_tstrb  = k;
    {pkt_i_tid, pkt_i_tdest, pkt_i_tuser} = idu;
    pkt_i_tlast  = l;
    exp_q.push_back(pack(1'b0, idu, k, k, d));
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 5000) begin
      @(negedge clk);
      acc = pkt_i_tready;
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    if (!acc) check("send_timeout", acc, 1);
    last_stall = waits;
  endtask

  task automatic send_frag(input int n, input logic [7:0] klast, input logic [63:0] trl);
    for (int i = 0; i < n; i++)
      send_beat({$urandom, $urandom}, (i == n - 1) ? klast : 8'hFF,
                (i == 0) ? 3'b101 : 3'b010, i == n - 1);
    exp_q.push_back(pack(1'b1, 3'b101, 8'hFF, 8'hFF, trl));
    pkt_i_tvalid = 1'b0;
    pkt_i_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int first_stall;
    rst_n        = 1'b0;
    pkt_i_tvalid = 1'b0;
    pkt_i_tdata  = '0;
    pkt_i_tkeep  = '0;
    pkt_i_tstrb  = '0;
    pkt_i_tid    = 1'b0;
    pkt_i_tdest  = 1'b0;
    pkt_i_tuser  = 1'b0;
    pkt_i_tlast  = 1'b0;

    // reset state
    do_reset(2);
    @(negedge clk);
    check("rst_tvalid", pkt_o_tvalid, 0);
    check("rst_tdata", pkt_o_tdata, 0);
    check("rst_tlast", pkt_o_tlast, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // 3-beat fragment FF,FF,0F: 20 bytes, 3 words, seq 0
    send_frag(3, 8'h0F, 64'h00A5_0003_0000_0014);
    wait_drain("drain_3beat");

    // back-to-back single-beat fragments, seq 0,1,2
    do_reset(2);
    send_frag(1, 8'hFF, 64'h00A5_0001_0000_0008);
    first_stall = last_stall;
    send_frag(1, 8'hFF, 64'h00A5_0001_0001_0008);
    check("bubble_frag1", last_stall, 2);
    send_frag(1, 8'hFF, 64'h00A5_0001_0002_0008);
    check("bubble_frag2", last_stall, 2);
    check("no_stall_after_reset", first_stall, 0);
    wait_drain("drain_single");

    // 64 full beats under random sink backpressure: 512 bytes
    do_reset(2);
    rnd_en = 1'b1;
    send_frag(64, 8'hFF, 64'h00A5_0040_0000_0200);
    wait_drain("drain_random");
    rnd_en = 1'b0;

    // MAX_FRAG_SIZE+8 bytes: ovf set, bytes saturate at 2048, 257 words
    do_reset(2);
    send_frag(257, 8'hFF, 64'h80A5_0101_0000_0800);
    wait_drain("drain_ovf");

    // reset mid-fragment after 2 of 5 beats, then a clean 3-beat fragment
    do_reset(2);
    mon_en = 1'b0;
    send_beat({$urandom, $urandom}, 8'hFF, 3'b101, 1'b0);
    send_beat({$urandom, $urandom}, 8'hFF, 3'b010, 1'b0);
    pkt_i_tvalid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_tvalid", pkt_o_tvalid, 0);
    check("rst_mid_state", dbg_state, 0);
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    send_frag(3, 8'h0F, 64'h00A5_0003_0000_0014);
    wait_drain("drain_after_mid_rst");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
